// File: rtl/jtsdram_pkg.sv
// rtl/jtsdram_pkg.sv - shared types and data pattern for the SDRAM responder stand-in
package jtsdram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RFSH  = 2'd3
  } jtsdram_state_e;

  localparam int CNT_W = 16;

  // Low half mixes address, bank and seed; high half is its complement.
  function automatic logic [31:0] jtsdram_pattern(input logic [1:0]  ba,
                                                  input logic [21:0] addr,
                                                  input logic [15:0] seed);
    logic [15:0] lo;
    lo = addr[15:0] ^ {addr[21:16], ba, 8'h00} ^ seed;
    return {~lo, lo};
  endfunction

endpackage

// File: rtl/jtsdram_rr4.sv
// rtl/jtsdram_rr4.sv - 4-way round-robin arbiter, first request at or after ptr wins
module jtsdram_rr4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic [1:0] idx,
  output logic       valid
);

  logic [1:0] cand;

  always_comb begin
    gnt   = 4'b0000;
    idx   = ptr;
    valid = 1'b0;
    cand  = ptr;
    // Scan farthest-first so the closest request to ptr is the last one kept.
    for (int i = 3; i >= 0; i--) begin
      cand = ptr + 2'(i);
      if (req[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
    if (valid) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/jtsdram_responder.sv
// rtl/jtsdram_responder.sv - SDRAM controller stand-in answering bank and prog requests
module jtsdram_responder
  import jtsdram_pkg::*;
#(
  parameter int          LATENCY  = 4,
  parameter int          RFSH_CYC = 8,
  parameter logic [15:0] SEED     = 16'hA55A
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  ba_rd,
  input  logic [87:0] ba_addr,
  output logic [3:0]  ba_ack,
  output logic [3:0]  ba_rdy,
  input  logic        prog_we,
  input  logic        prog_rd,
  input  logic [21:0] prog_addr,
  input  logic [1:0]  prog_ba,
  input  logic [15:0] prog_data,
  input  logic [1:0]  prog_mask,
  output logic        prog_ack,
  output logic        prog_rdy,
  output logic [31:0] data_read,
  input  logic        refresh_en,
  input  logic        err_inj,
  output logic        busy
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);
  localparam logic [CNT_W-1:0] RFSH_INIT = CNT_W'((RFSH_CYC > 1) ? RFSH_CYC - 1 : 0);

  jtsdram_state_e    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        ba_q, ba_d;
  logic [21:0]       addr_q, addr_d;
  logic              is_prog_q, is_prog_d;
  logic              is_wr_q, is_wr_d;
  logic              err_q, err_d;
  logic [3:0]        ba_ack_q, ba_ack_d;
  logic [3:0]        ba_rdy_q, ba_rdy_d;
  logic              prog_ack_q, prog_ack_d;
  logic              prog_rdy_q, prog_rdy_d;
  logic [31:0]       data_q, data_d;

  logic [3:0]        arb_gnt;
  logic [1:0]        arb_idx;
  logic              arb_valid;
  logic              fire;
  logic              err_now;
  logic              unused_prog_wdata;

  // Write payload has nowhere to go in this stand-in.
  assign unused_prog_wdata = ^{prog_data, prog_mask};

  jtsdram_rr4 u_rr4 (
    .req   (ba_rd),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    ba_d       = ba_q;
    addr_d     = addr_q;
    is_prog_d  = is_prog_q;
    is_wr_d    = is_wr_q;
    err_d      = err_q;
    ba_ack_d   = 4'b0000;
    ba_rdy_d   = 4'b0000;
    prog_ack_d = 1'b0;
    prog_rdy_d = 1'b0;
    data_d     = data_q;
    fire       = 1'b0;
    err_now    = err_q;

    case (state_q)
      ST_IDLE: begin
        if (prog_we || prog_rd) begin
          state_d    = ST_GRANT;
          is_prog_d  = 1'b1;
          is_wr_d    = prog_we;
          ba_d       = prog_ba;
          addr_d     = prog_addr;
          prog_ack_d = 1'b1;
        end else if (refresh_en) begin
          state_d = ST_RFSH;
          cnt_d   = RFSH_INIT;
        end else if (arb_valid) begin
          state_d   = ST_GRANT;
          is_prog_d = 1'b0;
          is_wr_d   = 1'b0;
          ba_d      = arb_idx;
          addr_d    = ba_addr[22*arb_idx +: 22];
          ba_ack_d  = arb_gnt;
        end
      end
      ST_GRANT: begin
        err_d = err_inj;
        if (!is_prog_q) ptr_d = ba_q + 2'd1;
        if (LATENCY <= 1) begin
          fire    = 1'b1;
          err_now = err_inj;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = WAIT_INIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          fire    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RFSH: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // rdy and data are registered, so they appear in the cycle after the final WAIT cycle.
    if (fire) begin
      if (is_prog_q) begin
        prog_rdy_d = 1'b1;
        if (!is_wr_q) data_d = jtsdram_pattern(ba_q, addr_q, SEED) ^ {31'd0, err_now};
      end else begin
        ba_rdy_d = 4'b0001 << ba_q;
        data_d   = jtsdram_pattern(ba_q, addr_q, SEED) ^ {31'd0, err_now};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ptr_q      <= 2'd0;
      ba_q       <= 2'd0;
      addr_q     <= 22'd0;
      is_prog_q  <= 1'b0;
      is_wr_q    <= 1'b0;
      err_q      <= 1'b0;
      ba_ack_q   <= 4'b0000;
      ba_rdy_q   <= 4'b0000;
      prog_ack_q <= 1'b0;
      prog_rdy_q <= 1'b0;
      data_q     <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      ba_q       <= ba_d;
      addr_q     <= addr_d;
      is_prog_q  <= is_prog_d;
      is_wr_q    <= is_wr_d;
      err_q      <= err_d;
      ba_ack_q   <= ba_ack_d;
      ba_rdy_q   <= ba_rdy_d;
      prog_ack_q <= prog_ack_d;
      prog_rdy_q <= prog_rdy_d;
      data_q     <= data_d;
    end
  end

  assign ba_ack    = ba_ack_q;
  assign ba_rdy    = ba_rdy_q;
  assign prog_ack  = prog_ack_q;
  assign prog_rdy  = prog_rdy_q;
  assign data_read = data_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
